// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data memory arbiter.
// Holds FSM encoding, port indices and the legal address window.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam logic [31:0] DMEM_BASE_D = 32'h0000_1000;
   localparam logic [31:0] DMEM_TOP_D  = 32'h0000_1FFF;
   localparam logic [31:0] LED_ADDR_D  = 32'h0000_2000;

   function automatic logic addr_ok(
      input logic [31:0] a,
      input logic [31:0] base,
      input logic [31:0] top,
      input logic [31:0] led
   );
      return ((a >= base) && (a <= top)) || (a == led);
   endfunction

endpackage

// File: rtl/dmem_req_slot.sv
// One-entry request buffer for a single requester.
// ready is high when empty or while the slot is being retired.
module dmem_req_slot
   import dmem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        clear,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   input  logic        we_in,
   input  logic [3:0]  mask_in,
   output logic        ready,
   output logic        valid,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        we,
   output logic [3:0]  mask
);

   logic load;

   assign ready = !valid || clear;
   assign load  = req && ready;

   // capture a new request; a load in the retire cycle wins over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         we    <= 1'b0;
         mask  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         addr  <= addr_in;
         wdata <= wdata_in;
         we    <= we_in;
         mask  <= mask_in;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the data memory strobe/stall protocol.
// Build option: DATA_MEM_ARB_ROUND_ROBIN_EN selects round-robin grants.
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE     = DMEM_BASE_D,
   parameter logic [31:0] DMEM_TOP      = DMEM_TOP_D,
   parameter logic [31:0] LED_ADDR      = LED_ADDR_D,
   parameter int          STALL_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   output logic        a_ready,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic        a_we,
   input  logic [3:0]  a_sign_mask,
   output logic        a_ack,
   output logic        a_err,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   output logic        b_ready,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   input  logic        b_we,
   input  logic [3:0]  b_sign_mask,
   output logic        b_ack,
   output logic        b_err,
   output logic [31:0] b_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memread,
   output logic        mem_memwrite,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall,
   output logic        busy
);

   localparam logic [7:0] TO_LAST = 8'(STALL_TIMEOUT - 1);

   state_t      state, nxt;
   logic        av, bv, awe, bwe;
   logic [31:0] aa, awd, ba, bwd;
   logic [3:0]  am, bm;
   logic        a_clr, b_clr;
   logic        gnt, win;
   logic [31:0] w_addr, w_wdata;
   logic        w_we;
   logic [3:0]  w_mask;
   logic [31:0] buf_addr, buf_wdata;
   logic        buf_we, buf_port, buf_err;
   logic [3:0]  buf_mask;
   logic        stall_seen, done, tmo;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        err_q;

   assign a_clr = (state == RESP) && (buf_port == PORT_A);
   assign b_clr = (state == RESP) && (buf_port == PORT_B);

   dmem_req_slot u_slot_a (
      .clk(clk), .rst_n(rst_n), .req(a_req), .clear(a_clr),
      .addr_in(a_addr), .wdata_in(a_wdata), .we_in(a_we),
      .mask_in(a_sign_mask), .ready(a_ready), .valid(av),
      .addr(aa), .wdata(awd), .we(awe), .mask(am)
   );

   dmem_req_slot u_slot_b (
      .clk(clk), .rst_n(rst_n), .req(b_req), .clear(b_clr),
      .addr_in(b_addr), .wdata_in(b_wdata), .we_in(b_we),
      .mask_in(b_sign_mask), .ready(b_ready), .valid(bv),
      .addr(ba), .wdata(bwd), .we(bwe), .mask(bm)
   );

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
   logic rr_next;

   // next port to favour on contention; flips to the other port per grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   rr_next <= PORT_A;
      else if (gnt) rr_next <= (win == PORT_A) ? PORT_B : PORT_A;
   end
`endif

   // pick a winner in IDLE once the memory is quiet
   always_comb begin
      gnt = 1'b0;
      win = PORT_A;
      if ((state == IDLE) && !mem_clk_stall) begin
         gnt = av || bv;
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
         if (av && bv) win = rr_next;
         else          win = av ? PORT_A : PORT_B;
`else
         win = av ? PORT_A : PORT_B;
`endif
      end
   end

   assign w_addr  = (win == PORT_A) ? aa  : ba;
   assign w_wdata = (win == PORT_A) ? awd : bwd;
   assign w_we    = (win == PORT_A) ? awe : bwe;
   assign w_mask  = (win == PORT_A) ? am  : bm;

   assign done = (state == WAIT) && stall_seen && !mem_clk_stall;
   assign tmo  = (state == WAIT) && !stall_seen
              && !mem_clk_stall && (cnt == TO_LAST);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // next state and memory strobes; rejected accesses pass ISSUE unstrobed
   always_comb begin
      nxt          = state;
      mem_memread  = 1'b0;
      mem_memwrite = 1'b0;
      case (state)
         IDLE:  if (gnt) nxt = ISSUE;
         ISSUE: begin
            mem_memread  = !buf_err && !buf_we;
            mem_memwrite = !buf_err && buf_we;
            nxt = buf_err ? RESP : WAIT;
         end
         WAIT:  if (done || tmo) nxt = RESP;
         RESP:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // issue buffer, stall tracking and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_addr   <= '0;
         buf_wdata  <= '0;
         buf_we     <= 1'b0;
         buf_mask   <= '0;
         buf_port   <= PORT_A;
         buf_err    <= 1'b0;
         cnt        <= '0;
         stall_seen <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         if (gnt) begin
            buf_addr   <= w_addr;
            buf_wdata  <= w_wdata;
            buf_we     <= w_we;
            buf_mask   <= w_mask;
            buf_port   <= win;
            buf_err    <= !addr_ok(w_addr, DMEM_BASE, DMEM_TOP, LED_ADDR);
            err_q      <= !addr_ok(w_addr, DMEM_BASE, DMEM_TOP, LED_ADDR);
            rdata_q    <= '0;
            cnt        <= '0;
            stall_seen <= 1'b0;
         end
         if ((state == ISSUE) || (state == WAIT)) begin
            cnt <= cnt + 8'd1;
            if (mem_clk_stall) stall_seen <= 1'b1;
         end
         if (done) rdata_q <= buf_we ? '0 : mem_read_data;
         if (tmo)  err_q   <= 1'b1;
      end
   end

   assign mem_addr       = buf_addr;
   assign mem_write_data = buf_wdata;
   assign mem_sign_mask  = buf_mask;

   assign a_ack   = a_clr;
   assign a_err   = a_clr && err_q;
   assign a_rdata = a_clr ? rdata_q : '0;
   assign b_ack   = b_clr;
   assign b_err   = b_clr && err_q;
   assign b_rdata = b_clr ? rdata_q : '0;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural data memory.
// Expected results come from a word-level reference memory and latency rules.
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 0, b_req = 0;
   logic        a_ready, b_ready;
   logic [31:0] a_addr = 0, a_wdata = 0;
   logic [31:0] b_addr = 0, b_wdata = 0;
   logic        a_we = 0, b_we = 0;
   logic [3:0]  a_sign_mask = 0, b_sign_mask = 0;
   logic        a_ack, a_err, b_ack, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [31:0] mem_addr, mem_write_data;
   logic        mem_memread, mem_memwrite;
   logic [3:0]  mem_sign_mask;
   logic [31:0] mem_read_data = 0;
   logic        mem_clk_stall;
   logic        busy;

   logic        stall_m = 1'b0;
   logic        stall_force = 1'b0;
   logic        mem_tie = 1'b0;
   int          scnt = 0;
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          ncmp = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   assign mem_clk_stall = stall_m | stall_force;

   data_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_ready(a_ready), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_we(a_we), .a_sign_mask(a_sign_mask),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_ready(b_ready), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_we(b_we), .b_sign_mask(b_sign_mask),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
      .mem_clk_stall(mem_clk_stall), .busy(busy)
   );

   // data memory: samples a strobe, stalls for two cycles, then idles
   always @(posedge clk) begin
      if (!mem_tie && (mem_memread || mem_memwrite)) begin
         if (mem_memwrite) mem_arr[mem_addr] = mem_write_data;
         else mem_read_data <= mem_arr.exists(mem_addr)
                               ? mem_arr[mem_addr] : 32'h0;
         stall_m <= 1'b1;
         scnt    <= 1;
      end else if (stall_m) begin
         if (scnt > 0) scnt <= scnt - 1;
         else          stall_m <= 1'b0;
      end
   end

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   function automatic bit legal(input logic [31:0] a);
      return (a >= 32'h1000 && a <= 32'h1FFF) || a == 32'h2000;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit p, input logic [31:0] ad,
                        input logic [31:0] wd, input bit we,
                        input logic [3:0] mk);
      if (!p) begin
         a_req = 1; a_addr = ad; a_wdata = wd;
         a_we = we; a_sign_mask = mk;
      end else begin
         b_req = 1; b_addr = ad; b_wdata = wd;
         b_we = we; b_sign_mask = mk;
      end
   endtask

   // one uncontested transaction; edge 0 is the accept edge
   task automatic run_txn(input bit p, input logic [31:0] ad,
                          input logic [31:0] wd, input bit we,
                          input bit to, input string tag);
      int lat, strb, exp_lat;
      logic [31:0] rd, exp_rd;
      logic er, exp_er, rdy;
      logic [3:0] mk;
      mk = 4'($urandom);
      exp_lat = legal(ad) ? 5 : 2;
      exp_er  = !legal(ad) || to;
      exp_rd  = (legal(ad) && !we && !to) ? ref_rd(ad) : 32'h0;
      if (legal(ad) && we && !to) ref_mem[ad] = wd;
      lat = 0; strb = 0; rd = 0; er = 0; rdy = 0;
      @(negedge clk);
      drive(p, ad, wd, we, mk);
      @(posedge clk);
      @(negedge clk);
      a_req = 0; b_req = 0;
      chk({tag, "_busy_ready"}, p ? b_ready : a_ready, 0);
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (mem_memread || mem_memwrite) begin
            strb++;
            chk({tag, "_maddr"}, mem_addr, ad);
            chk({tag, "_mmask"}, 32'(mem_sign_mask), 32'(mk));
            chk({tag, "_mwr"}, 32'(mem_memwrite), 32'(we));
         end
         if (p ? b_ack : a_ack) begin
            lat = k;
            rd  = p ? b_rdata : a_rdata;
            er  = p ? b_err : a_err;
            rdy = p ? b_ready : a_ready;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"}, 32'(er), 32'(exp_er));
      chk({tag, "_rdata"}, rd, exp_rd);
      chk({tag, "_strobes"}, 32'(strb), legal(ad) ? 32'd1 : 32'd0);
      chk({tag, "_ack_ready"}, 32'(rdy), 32'd1);
   endtask

   initial begin
      int la, lb, strb, lat;
      logic [31:0] rda, rdb, exp_b, ad, wd;
      bit b_first, p, we;

      repeat (2) @(negedge clk);
      chk("rst_a_ready", 32'(a_ready), 1);
      chk("rst_b_ready", 32'(b_ready), 1);
      chk("rst_acks", {a_ack, b_ack, a_err, b_err}, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobes", {mem_memread, mem_memwrite}, 0);
      chk("rst_maddr", mem_addr, 0);
      rst_n = 1'b1;

      run_txn(1, 32'h1004, 32'hDEADBEEF, 1, 0, "b_wr1004");
      run_txn(0, 32'h1004, 32'h0, 0, 0, "a_rd1004");
      run_txn(0, 32'h1008, 32'h0BADF00D, 1, 0, "a_wr1008");

      // simultaneous A write / B read of the same word
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
      b_first = 1;
`else
      b_first = 0;
`endif
      exp_b = b_first ? ref_rd(32'h1008) : 32'h12345678;
      ref_mem[32'h1008] = 32'h12345678;
      @(negedge clk);
      drive(0, 32'h1008, 32'h12345678, 1, 4'hF);
      drive(1, 32'h1008, 32'h0, 0, 4'hF);
      @(posedge clk);
      @(negedge clk);
      a_req = 0; b_req = 0;
      la = 0; lb = 0; rda = 0; rdb = 0;
      for (int k = 1; k <= 30 && (la == 0 || lb == 0); k++) begin
         @(negedge clk);
         if (a_ack) begin la = k; rda = a_rdata; end
         if (b_ack) begin lb = k; rdb = b_rdata; end
      end
      chk("sim_a_lat", 32'(la), b_first ? 32'd11 : 32'd5);
      chk("sim_b_lat", 32'(lb), b_first ? 32'd5 : 32'd11);
      chk("sim_b_rdata", rdb, exp_b);
      chk("sim_a_rdata", rda, 32'h0);

      run_txn(1, 32'h3000, 32'h0, 0, 0, "b_illegal");
      run_txn(0, 32'h1FFC, 32'h55AA00FF, 1, 0, "a_top_edge");
      run_txn(0, 32'h0FFC, 32'h0, 0, 0, "a_below_base");

      mem_tie = 1'b1;
      run_txn(0, 32'h1000, 32'h0, 0, 1, "a_timeout");
      mem_tie = 1'b0;
      @(negedge clk);
      chk("timeout_idle", 32'(busy), 0);

      run_txn(0, 32'h2000, 32'hA5, 1, 0, "a_led_wr");

      // reset while the memory is stalled in WAIT
      @(negedge clk);
      drive(0, 32'h1010, 32'h0, 0, 4'hF);
      @(posedge clk);
      @(negedge clk);
      a_req = 0;
      repeat (3) @(negedge clk);
      chk("mid_stalled", 32'(mem_clk_stall), 1);
      stall_force = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", {a_ack, b_ack}, 0);
      chk("mid_rst_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 32'h1004, 32'h0, 0, 4'hF);
      @(posedge clk);
      @(negedge clk);
      a_req = 0;
      strb = 0; la = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         strb += int'(mem_memread) + int'(mem_memwrite);
         la   += int'(a_ack) + int'(b_ack) + int'(busy);
      end
      chk("mid_no_strobe", 32'(strb), 0);
      chk("mid_no_ack_busy", 32'(la), 0);
      stall_force = 1'b0;
      lat = 0; rda = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(negedge clk);
         if (a_ack) begin lat = k; rda = a_rdata; end
      end
      chk("mid_after_lat", 32'(lat), 5);
      chk("mid_after_rdata", rda, ref_rd(32'h1004));

      // randomized traffic against the reference memory
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0, 1: ad = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            2:    ad = 32'h2000;
            default: ad = $urandom_range(0, 1) ? 32'h2004 : 32'h0FFC;
         endcase
         wd = $urandom;
         we = 1'($urandom_range(0, 1));
         p  = 1'($urandom_range(0, 1));
         run_txn(p, ad, wd, we, 0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
